// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fa_slice.sv
// One-bit full adder built from two half adders and an OR; purely combinational.
module fa_slice (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1, c1, c2;

    h_add u_ha0 (.x(x),  .y(y),   .s(s1), .c(c1));
    h_add u_ha1 (.x(s1), .y(cin), .s(s),  .c(c2));

    assign cout = c1 | c2;

endmodule

// File: rtl/h_add.sv
// Half adder: sum and carry of two bits.
module h_add (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder with valid/ready on both sides, LSB first, one bit per clock.
// Define SERIAL_ADD_SUB_EN to add the sub port (A-B via inverted B and carry-in of 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CNT_W = $clog2(W) + 1;

    state_t           state, state_nxt;
    logic [W-1:0]     a_sr, b_sr;
    logic [W-1:0]     b_cap;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cin;
    logic             accept;
    logic             last_bit;
    logic             slice_s, slice_c;

`ifdef SERIAL_ADD_SUB_EN
    assign b_cap = sub ? ~b : b;
    assign cin   = sub;
`else
    assign b_cap = b;
    assign cin   = 1'b0;
`endif

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt == CNT_W'(W - 1));
    assign cout     = carry;

    fa_slice u_slice (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .cin (carry),
        .s   (slice_s),
        .cout(slice_c)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sum bits enter at the MSB so the W-th shift leaves the result aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            sum   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b_cap;
            cnt   <= '0;
            carry <= cin;
        end else if (state == ST_SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            sum   <= {slice_s, sum[W-1:1]};
            carry <= slice_c;
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule
